// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-lane data-memory arbiter.
// Build option: define DMEM_ARB_ADMIN_PROT_EN to reject stores to the admin-key word.
package dmem_arb_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 64;
  localparam int unsigned PROT_WORD_DEF   = 0;

`ifdef DMEM_ARB_ADMIN_PROT_EN
  localparam bit ADMIN_PROT_EN = 1'b1;
`else
  localparam bit ADMIN_PROT_EN = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  typedef enum logic {
    LANE_0 = 1'b0,
    LANE_1 = 1'b1
  } lane_e;

  typedef struct packed {
    lane_e       lane;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Misaligned, out-of-range, or (when protection is built in) a store to the key word.
  function automatic logic access_err(input logic [31:0]  addr,
                                      input logic         we,
                                      input int unsigned  depth,
                                      input int unsigned  prot);
    logic [31:0] word;
    logic        err;
    word = {2'b00, addr[31:2]};
    err  = (addr[1:0] != 2'b00) || (word >= depth);
    if (ADMIN_PROT_EN && we && (word == prot)) begin
      err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-request round-robin arbiter; the pointer only moves after a contended grant.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  lane_e ptr_q, ptr_d;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        gnt   = (ptr_q == LANE_0) ? 2'b01 : 2'b10;
        ptr_d = (ptr_q == LANE_0) ? LANE_1 : LANE_0;
      end
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= LANE_0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-lane arbiter in front of a single-port data memory: accept, issue, respond.
// Build option: DMEM_ARB_ADMIN_PROT_EN (see dmem_arb_pkg) blocks stores to PROT_WORD.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned PROT_WORD   = PROT_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,

  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,

  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  logic [1:0]        req_vld;
  logic [1:0]        gnt;
  arb_state_e        state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              issue;
  logic              issue_err;
  logic              issue_lane;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic [1:0][31:0]  rsp_rdata_q, rsp_rdata_d;

  // Requests are masked during reset so ready is low and the pointer stays put.
  assign req_vld = {req1_valid, req0_valid} & {2{~rst}};

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (req_vld),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    if (gnt[1]) begin
      state_d     = ST_ISSUE;
      cmd_d.lane  = LANE_1;
      cmd_d.we    = req1_we;
      cmd_d.addr  = req1_addr;
      cmd_d.wdata = req1_wdata;
    end else if (gnt[0]) begin
      state_d     = ST_ISSUE;
      cmd_d.lane  = LANE_0;
      cmd_d.we    = req0_we;
      cmd_d.addr  = req0_addr;
      cmd_d.wdata = req0_wdata;
    end else begin
      state_d = ST_IDLE;
      cmd_d   = '0;
    end
  end

  // The issue stage is suppressed during reset, which drops the in-flight command.
  assign issue      = (state_q == ST_ISSUE) && !rst;
  assign issue_err  = access_err(cmd_q.addr, cmd_q.we, DEPTH_WORDS, PROT_WORD);
  assign issue_lane = (cmd_q.lane == LANE_1);

  assign mem_we = issue && cmd_q.we && !issue_err;
  assign mem_a  = issue ? cmd_q.addr  : '0;
  assign mem_wd = issue ? cmd_q.wdata : '0;

  always_comb begin
    rsp_valid_d = '0;
    rsp_err_d   = '0;
    rsp_rdata_d = '0;
    if (issue) begin
      rsp_valid_d[issue_lane] = 1'b1;
      rsp_err_d[issue_lane]   = issue_err;
      if (!cmd_q.we && !issue_err) begin
        rsp_rdata_d[issue_lane] = mem_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp0_rdata = rsp_rdata_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp1_err   = rsp_err_q[1];
  assign rsp1_rdata = rsp_rdata_q[1];

endmodule
